// File: rtl/load_store_unit.sv
// Load/store unit: turns a single load or store request into one memory
// transaction on a simple req/ready bus, with alignment checking, byte-lane
// steering for stores, sign/zero extension for loads and a bounded wait.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_op,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg,     state_next;
    logic [CNT_W-1:0]  wait_cnt_reg,  wait_cnt_next;
    logic [2:0]        size_reg,      size_next;
    logic [1:0]        lane_reg,      lane_next;
    logic              busy_reg,      busy_next;
    logic              done_reg,      done_next;
    logic              fault_reg,     fault_next;
    logic [31:0]       load_data_reg, load_data_next;
    logic              mem_req_reg,   mem_req_next;
    logic              mem_we_reg,    mem_we_next;
    logic [31:0]       mem_addr_reg,  mem_addr_next;
    logic [3:0]        mem_be_reg,    mem_be_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;

    logic              illegal;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       ld_ext;

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign fault     = fault_reg;
    assign load_data = load_data_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_be    = mem_be_reg;
    assign mem_wdata = mem_wdata_reg;

    // Legality of the requested access: size encoding, alignment, and no
    // unsigned variants for stores.
    always_comb begin
        illegal = 1'b0;
        case (funct3)
            3'b000, 3'b100: illegal = mem_op & funct3[2];
            3'b001, 3'b101: illegal = addr[0] | (mem_op & funct3[2]);
            3'b010:         illegal = (addr[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
    end

    // Store lane steering: replicate the datum across the word, enable only
    // the addressed lanes.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << addr[1:0];
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    // Load lane selection and extension, using the latched size and offset.
    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (lane_reg)
            2'd0: rd_byte = mem_rdata[7:0];
            2'd1: rd_byte = mem_rdata[15:8];
            2'd2: rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_ext  = mem_rdata;
        case (size_reg)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_ext = {24'b0, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_ext = {16'b0, rd_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        size_next      = size_reg;
        lane_next      = lane_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        fault_next     = fault_reg;
        load_data_next = load_data_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_be_next    = mem_be_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    busy_next = 1'b1;
                    if (illegal) begin
                        state_next     = DONE;
                        done_next      = 1'b1;
                        fault_next     = 1'b1;
                        load_data_next = 32'b0;
                    end else begin
                        state_next     = REQ;
                        wait_cnt_next  = '0;
                        size_next      = funct3;
                        lane_next      = addr[1:0];
                        mem_req_next   = 1'b1;
                        mem_we_next    = mem_op;
                        mem_addr_next  = {addr[31:2], 2'b00};
                        mem_be_next    = mem_op ? st_be : 4'b1111;
                        mem_wdata_next = mem_op ? st_wdata : 32'b0;
                    end
                end
            end
            REQ: begin
                // A ready response wins over the timeout in the same cycle.
                if (mem_ready) begin
                    state_next     = DONE;
                    mem_req_next   = 1'b0;
                    mem_we_next    = 1'b0;
                    done_next      = 1'b1;
                    fault_next     = 1'b0;
                    load_data_next = ld_ext;
                end else if (wait_cnt_reg == CNT_LAST) begin
                    state_next     = DONE;
                    mem_req_next   = 1'b0;
                    mem_we_next    = 1'b0;
                    done_next      = 1'b1;
                    fault_next     = 1'b1;
                    load_data_next = 32'b0;
                end else begin
                    wait_cnt_next  = wait_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                fault_next = 1'b0;
            end
            default: begin
                state_next   = IDLE;
                busy_next    = 1'b0;
                mem_req_next = 1'b0;
                mem_we_next  = 1'b0;
                fault_next   = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            size_reg      <= 3'b0;
            lane_reg      <= 2'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            load_data_reg <= 32'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'b0;
            mem_be_reg    <= 4'b0;
            mem_wdata_reg <= 32'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            size_reg      <= size_next;
            lane_reg      <= lane_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            fault_reg     <= fault_next;
            load_data_reg <= load_data_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_be_reg    <= mem_be_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

endmodule
